// File: rtl/mux2_stream_arbiter_pkg.sv
// Shared types for the mux2_stream_arbiter slice: lock states, grant encoding,
// source ids and the round-robin grant function.
package mux2_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        OPEN,
        LOCK_A,
        LOCK_B
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } grant_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Round-robin pick between two requesters; prio names the side that wins a tie.
    function automatic grant_t arbitrate(input logic a_req, input logic b_req, input logic prio);
        grant_t g;
        g = GNT_NONE;
        if (a_req && b_req) begin
            g = (prio == SRC_B) ? GNT_B : GNT_A;
        end else if (a_req) begin
            g = GNT_A;
        end else if (b_req) begin
            g = GNT_B;
        end
        return g;
    endfunction

endpackage

// File: rtl/mux2_stream_out_slot.sv
// One-entry registered output slot: accepts a payload when load is offered,
// holds it under back-pressure and replaces it in the same edge it drains.
module mux2_stream_out_slot #(
    parameter int unsigned PW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [PW-1:0] in_payload,
    input  logic          out_ready,
    output logic          load,
    output logic          out_valid,
    output logic [PW-1:0] out_payload
);

    logic          valid_q, valid_d;
    logic [PW-1:0] payload_q, payload_d;

    always_comb begin
        load      = !valid_q || out_ready;
        valid_d   = valid_q;
        payload_d = payload_q;
        if (in_valid) begin
            valid_d   = 1'b1;
            payload_d = in_payload;
        end else if (out_ready) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_payload = payload_q;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin 2:1 valid/ready stream arbiter with registered output slot.
// Define MUX2_STREAM_ARBITER_PKT_LOCK_EN to hold the grant for a whole packet.
module mux2_stream_arbiter
    import mux2_stream_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);

    localparam int unsigned PW = WIDTH + 2;

    logic             prio_q, prio_d;
    grant_t           grant;
    logic             slot_load;
    logic             xfer;
    logic             sel_src;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [PW-1:0]    slot_in;
    logic [PW-1:0]    slot_out;

`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
    arb_state_t state_q, state_d;
`endif

    always_comb begin
        grant = GNT_NONE;
`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
        case (state_q)
            LOCK_A:  grant = a_valid ? GNT_A : GNT_NONE;
            LOCK_B:  grant = b_valid ? GNT_B : GNT_NONE;
            default: grant = arbitrate(a_valid, b_valid, prio_q);
        endcase
`else
        grant = arbitrate(a_valid, b_valid, prio_q);
`endif
    end

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    assign a_ready  = rst_n && slot_load && (grant == GNT_A);
    assign b_ready  = rst_n && slot_load && (grant == GNT_B);
    assign xfer     = (a_valid && a_ready) || (b_valid && b_ready);

    assign sel_src  = (grant == GNT_B) ? SRC_B : SRC_A;
    assign sel_data = (grant == GNT_B) ? b_data : a_data;
    assign sel_last = (grant == GNT_B) ? b_last : a_last;
    assign slot_in  = {sel_last, sel_src, sel_data};

    always_comb begin
        prio_d = prio_q;
`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
        state_d = state_q;
        if (xfer) begin
            if (sel_last) begin
                prio_d  = ~sel_src;
                state_d = OPEN;
            end else begin
                state_d = (sel_src == SRC_A) ? LOCK_A : LOCK_B;
            end
        end
`else
        if (xfer) begin
            prio_d = ~sel_src;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= SRC_A;
        end else begin
            prio_q <= prio_d;
        end
    end

`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OPEN;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    mux2_stream_out_slot #(
        .PW(PW)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (xfer),
        .in_payload (slot_in),
        .out_ready  (out_ready),
        .load       (slot_load),
        .out_valid  (out_valid),
        .out_payload(slot_out)
    );

    assign out_last = slot_out[PW-1];
    assign out_src  = slot_out[PW-2];
    assign out_data = slot_out[WIDTH-1:0];

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Directed self-checking bench for mux2_stream_arbiter (lock expectations follow
// MUX2_STREAM_ARBITER_PKT_LOCK_EN).
module tb_mux2_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, a_last, a_ready;
    logic [7:0] a_data;
    logic       b_valid, b_last, b_ready;
    logic [7:0] b_data;
    logic       out_valid, out_last, out_src, out_ready;
    logic [7:0] out_data;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mux2_stream_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_src(out_src), .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
        a_data = 8'h00; b_data = 8'h00; out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
        a_last = 1'b1; b_last = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        compared++;
        if ({a_ready, b_ready} !== 2'b00) begin mismatched++; $display("FAIL reset_readies got=%b exp=00", {a_ready, b_ready}); end
        compared++;
        if ({out_data, out_last, out_src} !== 10'h000) begin mismatched++; $display("FAIL reset_fields got=%h/%b/%b exp=00/0/0", out_data, out_last, out_src); end
        rst_n = 1'b1;
        #1;
        compared++;
        if ({a_ready, b_ready} !== 2'b10) begin mismatched++; $display("FAIL reset_first_grant got=%b exp=10", {a_ready, b_ready}); end
        tick();
        compared++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'h11, 1'b0}) begin mismatched++; $display("FAIL reset_first_beat got=%b/%h/%b exp=1/11/0", out_valid, out_data, out_src); end
    endtask

    task automatic test_fairness();
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
        a_last = 1'b1; b_last = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            compared++;
            if ({out_valid, out_data, out_src} !== {1'b1, (i % 2 == 0) ? 8'h11 : 8'h22, (i % 2 == 1)})
                begin mismatched++; $display("FAIL fairness_beat%0d got=%b/%h/%b exp=1/%h/%0d", i, out_valid, out_data, out_src, (i % 2 == 0) ? 8'h11 : 8'h22, i % 2); end
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1; out_ready = 1'b0;
        tick();
        compared++;
        if ({out_valid, out_data} !== {1'b1, 8'h11}) begin mismatched++; $display("FAIL stall_load got=%b/%h exp=1/11", out_valid, out_data); end
        b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if ({a_ready, b_ready} !== 2'b00) begin mismatched++; $display("FAIL stall_readies%0d got=%b exp=00", i, {a_ready, b_ready}); end
            tick();
            compared++;
            if ({out_valid, out_data, out_src} !== {1'b1, 8'h11, 1'b0}) begin mismatched++; $display("FAIL stall_hold%0d got=%b/%h/%b exp=1/11/0", i, out_valid, out_data, out_src); end
        end
        out_ready = 1'b1;
        #1;
        compared++;
        if ({a_ready, b_ready} !== 2'b01) begin mismatched++; $display("FAIL stall_release_grant got=%b exp=01", {a_ready, b_ready}); end
        tick();
        compared++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'h22, 1'b1}) begin mismatched++; $display("FAIL stall_no_bubble got=%b/%h/%b exp=1/22/1", out_valid, out_data, out_src); end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        compared++;
        if ({out_valid, out_data, out_src} !== {1'b0, 8'h22, 1'b1}) begin mismatched++; $display("FAIL drain_hold got=%b/%h/%b exp=0/22/1", out_valid, out_data, out_src); end
    endtask

    task automatic test_single_source();
        do_reset();
        b_valid = 1'b1; b_data = 8'h33; b_last = 1'b1; out_ready = 1'b1;
        #1;
        compared++;
        if ({a_ready, b_ready} !== 2'b01) begin mismatched++; $display("FAIL single_grant got=%b exp=01", {a_ready, b_ready}); end
        tick();
        compared++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'h33, 1'b1}) begin mismatched++; $display("FAIL single_beat0 got=%b/%h/%b exp=1/33/1", out_valid, out_data, out_src); end
        b_data = 8'h44;
        tick();
        compared++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'h44, 1'b1}) begin mismatched++; $display("FAIL single_beat1 got=%b/%h/%b exp=1/44/1", out_valid, out_data, out_src); end
        b_valid = 1'b0;
        tick();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL single_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_lock();
        logic [7:0] a_tbl [4];
        logic       l_tbl [4];
        logic [7:0] exp_data [4];
        logic       exp_src  [4];
        logic       acc;
        int         a_idx;
        a_tbl = '{8'hA1, 8'hA2, 8'hA3, 8'h00};
        l_tbl = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
        exp_data = '{8'hA1, 8'hA2, 8'hA3, 8'h22};
        exp_src  = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_data = '{8'hA1, 8'h22, 8'hA2, 8'h22};
        exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        do_reset();
        b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1; out_ready = 1'b1;
        a_idx = 0;
        for (int i = 0; i < 4; i++) begin
            a_valid = (a_idx < 3);
            a_data  = a_tbl[a_idx];
            a_last  = l_tbl[a_idx];
            #1;
            acc = a_valid && a_ready;
            tick();
            compared++;
            if ({out_valid, out_data, out_src} !== {1'b1, exp_data[i], exp_src[i]})
                begin mismatched++; $display("FAIL lock_beat%0d got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_data, out_src, exp_data[i], exp_src[i]); end
            if (acc) a_idx++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        a_valid = 1'b1; a_data = 8'h55; a_last = 1'b0;
        b_valid = 1'b1; b_data = 8'h66; b_last = 1'b1; out_ready = 1'b1;
        tick();
        compared++;
        if ({out_valid, out_data} !== {1'b1, 8'h55}) begin mismatched++; $display("FAIL areset_pre got=%b/%h exp=1/55", out_valid, out_data); end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({out_valid, a_ready, b_ready} !== 3'b000) begin mismatched++; $display("FAIL areset_immediate got=%b exp=000", {out_valid, a_ready, b_ready}); end
        tick();
        rst_n = 1'b1;
        a_valid = 1'b0;
        #1;
        compared++;
        if ({a_ready, b_ready} !== 2'b01) begin mismatched++; $display("FAIL areset_open got=%b exp=01", {a_ready, b_ready}); end
        a_valid = 1'b1;
        #1;
        compared++;
        if ({a_ready, b_ready} !== 2'b10) begin mismatched++; $display("FAIL areset_prio_a got=%b exp=10", {a_ready, b_ready}); end
        tick();
        compared++;
        if ({out_valid, out_data, out_src} !== {1'b1, 8'h55, 1'b0}) begin mismatched++; $display("FAIL areset_first got=%b/%h/%b exp=1/55/0", out_valid, out_data, out_src); end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fairness();
        test_stall();
        test_single_source();
        test_lock();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
